// File: rtl/main_comparator.sv
// main_comparator: registered A==B compare with a saturating match counter.
// Define MAIN_CMP_MAGNITUDE_EN to also build registered LT/GT outputs.
module main_comparator #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             S,
  output logic             out_valid,
  output logic [CNT_W-1:0] match_cnt
`ifdef MAIN_CMP_MAGNITUDE_EN
  ,
  output logic             LT,
  output logic             GT
`endif
);

  logic             eq;
  logic             cnt_sat;
  logic             s_q, s_d;
  logic             v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Operands only matter when in_valid is set, so idle X/Z cannot leak.
  assign eq      = in_valid && (A == B);
  assign cnt_sat = &cnt_q;

  always_comb begin
    s_d   = s_q;
    v_d   = in_valid;
    cnt_d = cnt_q;
    if (in_valid) begin
      s_d = eq;
      if (eq && !cnt_sat) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= 1'b0;
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  assign S         = s_q;
  assign out_valid = v_q;
  assign match_cnt = cnt_q;

`ifdef MAIN_CMP_MAGNITUDE_EN
  logic lt_q, lt_d;
  logic gt_q, gt_d;

  always_comb begin
    lt_d = lt_q;
    gt_d = gt_q;
    if (in_valid) begin
      lt_d = (A < B);
      gt_d = (A > B);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lt_q <= 1'b0;
      gt_q <= 1'b0;
    end else begin
      lt_q <= lt_d;
      gt_q <= gt_d;
    end
  end

  assign LT = lt_q;
  assign GT = gt_q;
`endif

endmodule

// File: tb/tb_main_comparator.sv
// tb_main_comparator: directed + random checks of main_comparator
// against a behavioural model, with CNT_W=8 and CNT_W=2 instances.
module tb_main_comparator;

  localparam int W    = 2;
  localparam int MAX1 = 255;
  localparam int MAX2 = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] A, B;

  logic         S1, ov1;
  logic [7:0]   cnt1;
  logic         S2, ov2;
  logic [1:0]   cnt2;
`ifdef MAIN_CMP_MAGNITUDE_EN
  logic         LT1, GT1, LT2, GT2;
`endif

  always #5 clk = ~clk;

  main_comparator #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
    .S(S1), .out_valid(ov1), .match_cnt(cnt1)
`ifdef MAIN_CMP_MAGNITUDE_EN
    , .LT(LT1), .GT(GT1)
`endif
  );

  main_comparator #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
    .S(S2), .out_valid(ov2), .match_cnt(cnt2)
`ifdef MAIN_CMP_MAGNITUDE_EN
    , .LT(LT2), .GT(GT2)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: last-result registers and integer match counts.
  bit started = 1'b0;
  int m_s, m_ov, m_lt, m_gt, m_c1, m_c2;

  always @(posedge clk) begin
    if (rst) begin
      started <= 1'b1;
      m_s <= 0; m_ov <= 0; m_lt <= 0; m_gt <= 0;
      m_c1 <= 0; m_c2 <= 0;
    end else if (in_valid) begin
      m_ov <= 1;
      m_s  <= (int'(A) == int'(B)) ? 1 : 0;
      m_lt <= (int'(A) <  int'(B)) ? 1 : 0;
      m_gt <= (int'(A) >  int'(B)) ? 1 : 0;
      if (int'(A) == int'(B)) begin
        m_c1 <= (m_c1 + 1 > MAX1) ? MAX1 : m_c1 + 1;
        m_c2 <= (m_c2 + 1 > MAX2) ? MAX2 : m_c2 + 1;
      end
    end else begin
      m_ov <= 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("S",         int'(S1),   m_s);
      chk("out_valid", int'(ov1),  m_ov);
      chk("match_cnt", int'(cnt1), m_c1);
      chk("S_w2",      int'(S2),   m_s);
      chk("ov_w2",     int'(ov2),  m_ov);
      chk("cnt_w2",    int'(cnt2), m_c2);
`ifdef MAIN_CMP_MAGNITUDE_EN
      chk("LT",        int'(LT1),  m_lt);
      chk("GT",        int'(GT1),  m_gt);
      chk("LT_w2",     int'(LT2),  m_lt);
      chk("GT_w2",     int'(GT2),  m_gt);
      if (ov1) chk("one_hot", int'(S1) + int'(LT1) + int'(GT1), 1);
`endif
    end
  end

  // Apply inputs at a falling edge, return at the next falling edge.
  task automatic cyc(input bit r, input bit v, input int a, input int b);
    rst      = r;
    in_valid = v;
    A        = W'(a);
    B        = W'(b);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0;
    @(negedge clk);
    cyc(1, 1, 1, 1);
    cyc(1, 0, 0, 0);
    chk("rst_S",   int'(S1),   0);
    chk("rst_ov",  int'(ov1),  0);
    chk("rst_cnt", int'(cnt1), 0);

    cyc(0, 1, 2, 3);
    chk("ne_S",  int'(S1),  0);
    chk("ne_ov", int'(ov1), 1);
`ifdef MAIN_CMP_MAGNITUDE_EN
    chk("ne_LT", int'(LT1), 1);
    chk("ne_GT", int'(GT1), 0);
`endif
    cyc(0, 1, 1, 1);
    chk("eq1_S", int'(S1), 1);
    cyc(0, 1, 2, 2);
    chk("eq2_S",   int'(S1),   1);
    chk("eq2_cnt", int'(cnt1), 2);
    cyc(0, 1, 2, 1);
    chk("gt_S",   int'(S1),   0);
    chk("gt_cnt", int'(cnt1), 2);
`ifdef MAIN_CMP_MAGNITUDE_EN
    chk("gt_GT", int'(GT1), 1);
`endif
    cyc(0, 1, 3, 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, $urandom, $urandom);
    chk("idle_ov",  int'(ov1),  0);
    chk("idle_S",   int'(S1),   1);
    chk("idle_cnt", int'(cnt1), 3);

    for (int i = 0; i < 2; i++) cyc(0, 1, i, i);
    chk("sat_cnt2", int'(cnt2), 3);
    chk("cnt_5",    int'(cnt1), 5);
    cyc(1, 1, 0, 0);
    chk("mid_rst_cnt",  int'(cnt1), 0);
    chk("mid_rst_cnt2", int'(cnt2), 0);
    chk("mid_rst_S",    int'(S1),   0);
    chk("mid_rst_ov",   int'(ov1),  0);

    for (int i = 0; i < 300; i++) begin
      int x;
      x = $urandom_range(0, 3);
      cyc(0, 1, x, x);
    end
    chk("sat_cnt8", int'(cnt1), 255);
    cyc(0, 1, 1, 2);
    chk("sat_hold", int'(cnt1), 255);

    for (int i = 0; i < 3000; i++) begin
      bit r, v;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        int x;
        x = $urandom_range(0, 3);
        cyc(r, v, x, x);
      end else begin
        cyc(r, v, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
